// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: shares the write port of a single-clock FIFO between
// NREQ producers. The arbiter grants in round-robin order and holds each
// grant for a burst of up to BURST words. It stalls on fifo_full and
// releases the grant early when the owner drops its request.
module fifo_wr_arbiter #(
    parameter int BITS  = 8,
    parameter int NREQ  = 4,
    parameter int BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_i,
    input  logic [NREQ*BITS-1:0] req_data_i,
    output logic [NREQ-1:0]      ack_o,
    output logic [NREQ-1:0]      gnt_o,
    output logic                 busy_o,
    input  logic                 fifo_full_i,
    output logic                 fifo_wr_o,
    output logic [BITS-1:0]      fifo_wdata_o
);

    localparam int CW = $clog2(BURST + 1);
    localparam int IW = $clog2(NREQ);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    localparam logic [CW-1:0] CNT_LAST  = CW'(BURST - 1);
    localparam logic [IW-1:0] LAST_INIT = IW'(NREQ - 1);

    logic [0:0]      state_q, state_d;
    logic [NREQ-1:0] gnt_q, gnt_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [IW-1:0]   last_q, last_d;

    logic [IW-1:0]   scanIdx;
    logic [IW-1:0]   winner;
    logic [NREQ-1:0] winnerOh;
    logic            anyReq;
    logic            ownerReq;
    logic            ownerAck;
    logic            release_w;

    // Round-robin pick: scan from last+1 and wrap, so the previous owner is tried last.
    always_comb begin
        scanIdx = '0;
        winner  = '0;
        for (int k = NREQ; k >= 1; k--) begin
            scanIdx = IW'((int'(last_q) + k) % NREQ);
            if (req_i[scanIdx]) begin
                winner = scanIdx;
            end
        end
        winnerOh = NREQ'(1) << winner;
        anyReq   = |req_i;
    end

    // Write-side outputs; reset forces the strobes low so no word is lost.
    always_comb begin
        ack_o        = rst ? '0 : (gnt_q & req_i & {NREQ{~fifo_full_i}});
        fifo_wr_o    = |ack_o;
        fifo_wdata_o = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_q[i]) begin
                fifo_wdata_o = req_data_i[i*BITS +: BITS];
            end
        end
        gnt_o     = gnt_q;
        busy_o    = (state_q == ST_GRANT);
        ownerReq  = |(gnt_q & req_i);
        ownerAck  = |ack_o;
        release_w = (ownerAck && (cnt_q == CNT_LAST)) || !ownerReq;
    end

    // Next-state logic: grant from idle, count burst words, hand over on release.
    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        case (state_q)
            ST_IDLE: begin
                if (anyReq) begin
                    state_d = ST_GRANT;
                    gnt_d   = winnerOh;
                    cnt_d   = '0;
                    last_d  = winner;
                end
            end
            ST_GRANT: begin
                if (ownerAck) begin
                    cnt_d = cnt_q + 1'b1;
                end
                if (release_w) begin
                    cnt_d = '0;
                    if (anyReq) begin
                        gnt_d  = winnerOh;
                        last_d = winner;
                    end else begin
                        state_d = ST_IDLE;
                        gnt_d   = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State registers with synchronous reset; requester 0 wins the first search.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            cnt_q   <= '0;
            last_q  <= LAST_INIT;
        end else begin
            state_q <= state_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: table vectors, directed corner sequences and random
// traffic for fifo_wr_arbiter, checked against an integer-level model.
module tb_fifo_wr_arbiter;

    localparam int BITS  = 8;
    localparam int NREQ  = 4;
    localparam int BURST = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req = '0;
    logic [31:0] reqData = '0;
    logic        full = 1'b0;
    logic [3:0]  ack, gnt;
    logic        busy, wr;
    logic [7:0]  wdata;

    logic        rst1 = 1'b1;
    logic [2:0]  req1 = '0;
    logic [23:0] reqData1 = '0;
    logic        full1 = 1'b0;
    logic [2:0]  ack1, gnt1;
    logic        busy1, wr1;
    logic [7:0]  wdata1;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: owner index (-1 = idle), words in burst, last owner.
    int mOwner = -1;
    int mWords = 0;
    int mLast  = NREQ - 1;

    typedef struct {
        logic       r;
        logic [3:0] rq;
        logic       f;
        logic [3:0] eGnt;
        logic [3:0] eAck;
        logic       eBusy;
    } vec_t;

    vec_t tbl[10];

    always #5 clk = ~clk;

    fifo_wr_arbiter #(.BITS(BITS), .NREQ(NREQ), .BURST(BURST)) dut (
        .clk(clk), .rst(rst), .req_i(req), .req_data_i(reqData),
        .ack_o(ack), .gnt_o(gnt), .busy_o(busy),
        .fifo_full_i(full), .fifo_wr_o(wr), .fifo_wdata_o(wdata)
    );

    fifo_wr_arbiter #(.BITS(8), .NREQ(3), .BURST(1)) dut1 (
        .clk(clk), .rst(rst1), .req_i(req1), .req_data_i(reqData1),
        .ack_o(ack1), .gnt_o(gnt1), .busy_o(busy1),
        .fifo_full_i(full1), .fifo_wr_o(wr1), .fifo_wdata_o(wdata1)
    );

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Fair search order: requesters after the last owner, wrapping, the last owner at the end.
    function automatic int mPick(input logic [3:0] r, input int lastIdx);
        int order[$];
        for (int k = 1; k <= NREQ; k++) order.push_back((lastIdx + k) % NREQ);
        foreach (order[j]) if (r[order[j]]) return order[j];
        return -1;
    endfunction

    task automatic checkOutput();
        logic [31:0] eGnt, eAck, eData;
        eGnt  = (mOwner < 0) ? 32'd0 : (32'd1 << mOwner);
        eAck  = (!rst && mOwner >= 0 && req[mOwner] && !full) ? eGnt : 32'd0;
        eData = (mOwner < 0) ? 32'd0 : 32'(reqData[mOwner*8 +: 8]);
        checkVal("model gnt", 32'(gnt), eGnt);
        checkVal("model ack", 32'(ack), eAck);
        checkVal("model wr", 32'(wr), 32'(eAck != 0));
        checkVal("model busy", 32'(busy), 32'(mOwner >= 0));
        checkVal("model wdata", 32'(wdata), eData);
    endtask

    task automatic modelAdvance();
        int  w;
        bit  acked;
        if (rst) begin
            mOwner = -1; mWords = 0; mLast = NREQ - 1;
        end else if (mOwner < 0) begin
            w = mPick(req, mLast);
            if (w >= 0) begin
                mOwner = w; mWords = 0; mLast = w;
            end
        end else begin
            acked = req[mOwner] && !full;
            if (acked) mWords++;
            if ((acked && mWords == BURST) || !req[mOwner]) begin
                w = mPick(req, mLast);
                if (w >= 0) begin
                    mOwner = w; mLast = w;
                end else begin
                    mOwner = -1;
                end
                mWords = 0;
            end
        end
    endtask

    task automatic applyStimulus(input logic r, input logic [3:0] rq, input logic f);
        @(negedge clk);
        rst  = r;
        req  = rq;
        full = f;
        for (int i = 0; i < NREQ; i++) reqData[i*8 +: 8] = 8'($urandom);
        #1;
        checkOutput();
    endtask

    task automatic advance();
        @(posedge clk);
        modelAdvance();
    endtask

    task automatic step(input logic r, input logic [3:0] rq, input logic f);
        applyStimulus(r, rq, f);
        advance();
    endtask

    initial begin
        logic [3:0] rq;

        // Single requester with six words: two bursts, no gap, then idle.
        tbl[0] = '{1'b1, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0};
        tbl[1] = '{1'b0, 4'b0001, 1'b0, 4'b0000, 4'b0000, 1'b0};
        for (int i = 2; i < 8; i++) tbl[i] = '{1'b0, 4'b0001, 1'b0, 4'b0001, 4'b0001, 1'b1};
        tbl[8] = '{1'b0, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1};
        tbl[9] = '{1'b0, 4'b0000, 1'b0, 4'b0000, 4'b0000, 1'b0};

        $display("[TB] table vectors");
        foreach (tbl[i]) begin
            applyStimulus(tbl[i].r, tbl[i].rq, tbl[i].f);
            checkVal("tbl gnt", 32'(gnt), 32'(tbl[i].eGnt));
            checkVal("tbl ack", 32'(ack), 32'(tbl[i].eAck));
            checkVal("tbl wr", 32'(wr), 32'(|tbl[i].eAck));
            checkVal("tbl busy", 32'(busy), 32'(tbl[i].eBusy));
            advance();
        end

        $display("[TB] all requesters, round robin");
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b1111, 1'b0);
        for (int c = 0; c < 20; c++) begin
            applyStimulus(1'b0, 4'b1111, 1'b0);
            checkVal("rr gnt", 32'(gnt), 32'd1 << ((c / 4) % 4));
            checkVal("rr wr", 32'(wr), 32'd1);
            checkVal("rr busy", 32'(busy), 32'd1);
            advance();
        end

        $display("[TB] full stall mid-burst");
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b1100, 1'b0);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 4'b1100, 1'b0);
            checkVal("stall pre ack", 32'(ack), 32'b0100);
            advance();
        end
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1'b0, 4'b1100, 1'b1);
            checkVal("stall wr", 32'(wr), 32'd0);
            checkVal("stall ack", 32'(ack), 32'd0);
            checkVal("stall gnt", 32'(gnt), 32'b0100);
            advance();
        end
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 4'b1100, 1'b0);
            checkVal("stall post ack", 32'(ack), 32'b0100);
            advance();
        end
        applyStimulus(1'b0, 4'b1100, 1'b0);
        checkVal("stall handover gnt", 32'(gnt), 32'b1000);
        advance();

        $display("[TB] owner drops request");
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b1010, 1'b0);
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1'b0, 4'b1010, 1'b0);
            checkVal("drop ack", 32'(ack), 32'b0010);
            advance();
        end
        applyStimulus(1'b0, 4'b1000, 1'b0);
        checkVal("drop cycle gnt", 32'(gnt), 32'b0010);
        checkVal("drop cycle wr", 32'(wr), 32'd0);
        advance();
        applyStimulus(1'b0, 4'b1000, 1'b0);
        checkVal("drop next gnt", 32'(gnt), 32'b1000);
        checkVal("drop next ack", 32'(ack), 32'b1000);
        advance();

        $display("[TB] reset mid-burst");
        step(1'b1, 4'b0000, 1'b0);
        step(1'b0, 4'b1000, 1'b0);
        applyStimulus(1'b0, 4'b1000, 1'b0);
        checkVal("rst pre ack", 32'(ack), 32'b1000);
        advance();
        applyStimulus(1'b1, 4'b1001, 1'b0);
        checkVal("rst cycle wr", 32'(wr), 32'd0);
        checkVal("rst cycle ack", 32'(ack), 32'd0);
        advance();
        applyStimulus(1'b0, 4'b1001, 1'b0);
        checkVal("rst after gnt", 32'(gnt), 32'd0);
        checkVal("rst after busy", 32'(busy), 32'd0);
        advance();
        applyStimulus(1'b0, 4'b1001, 1'b0);
        checkVal("rst regrant gnt", 32'(gnt), 32'b0001);
        advance();

        $display("[TB] random traffic");
        rq = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) rq[b] = ~rq[b];
            applyStimulus(logic'($urandom_range(0, 49) == 0), rq, logic'($urandom_range(0, 3) == 0));
            if (wr && full) checkVal("wr while full", 32'(wr), 32'd0);
            advance();
        end

        $display("[TB] BURST=1, three requesters");
        @(negedge clk);
        rst1 = 1'b0;
        req1 = 3'b101;
        reqData1 = 24'hC2B1A0;
        #1;
        checkVal("b1 idle gnt", 32'(gnt1), 32'd0);
        for (int c = 0; c < 6; c++) begin
            int eo;
            @(posedge clk);
            @(negedge clk);
            reqData1 = 24'($urandom);
            #1;
            eo = (c % 2 == 0) ? 0 : 2;
            checkVal("b1 gnt", 32'(gnt1), 32'd1 << eo);
            checkVal("b1 ack", 32'(ack1), 32'd1 << eo);
            checkVal("b1 wr", 32'(wr1), 32'd1);
            checkVal("b1 wdata", 32'(wdata1), 32'(reqData1[eo*8 +: 8]));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
